// File: rtl/mem_responder.sv
// Word-organised RAM behind valid/ready request and response channels, with
// a programmable wait-state delay and error reporting for bad addresses.
//
// state | meaning
// IDLE  | ready for a request; accepts on req_valid
// WAIT  | counting down wait states; access happens when counter hits 0
// RESP  | response held on rsp_* until rsp_ready
module mem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0] offset;
    logic        addr_ok;
    logic [AW-1:0] idx;
    logic        access;
    logic        mem_we;

    // BASE_ADDR is span-aligned, so an address below the base wraps to an
    // offset at or above the span and the single compare covers both bounds.
    assign offset  = addr_q - BASE_ADDR;
    assign addr_ok = (offset[1:0] == 2'b00) && ({1'b0, offset} < SPAN_BYTES);
    assign idx     = offset[AW+1:2];
    assign access  = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign mem_we  = access && we_q && addr_ok;

    assign req_ready = reset && (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    err_d   = !addr_ok;
                    rdata_d = (addr_ok && !we_q) ? mem_q[idx] : 32'd0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wstrb_q <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM contents survive reset; a reset before the access edge parks the
    // FSM in IDLE so no pending store can land.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb_q[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a transaction-level memory model predicts
// every cycle's outputs, and literal expectations pin key results.
module tb_mem_responder;

    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned WAITC  = 2;
    localparam logic [31:0] BASE   = 32'h0000_0000;
    localparam int          BUDGET = 60;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_wstrb = 4'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(WAITC),
        .BASE_ADDR  (BASE)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [31:0] m_mem [DEPTH];
    bit          m_known [DEPTH];
    bit          m_busy = 1'b0;
    bit          m_shown = 1'b0;
    longint      m_edge = 0;
    longint      m_access_edge = 0;
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata = 32'd0;
    logic        m_err = 1'b0;
    bit          m_rknown = 1'b1;

    function automatic bit in_range(input logic [31:0] a);
        longint unsigned av = a;
        longint unsigned lo = BASE;
        longint unsigned hi = lo + 4 * longint'(DEPTH);
        return (a[1:0] == 2'b00) && (av >= lo) && (av < hi);
    endfunction

    task automatic m_access();
        int unsigned idx;
        m_err    = !in_range(m_addr);
        m_rdata  = 32'd0;
        m_rknown = 1'b1;
        if (!m_err) begin
            idx = (m_addr - BASE) / 4;
            if (m_we) begin
                for (int b = 0; b < 4; b++)
                    if (m_wstrb[b]) m_mem[idx][8*b +: 8] = m_wdata[8*b +: 8];
                if (m_wstrb == 4'hF) m_known[idx] = 1'b1;
            end else begin
                m_rdata  = m_mem[idx];
                m_rknown = m_known[idx];
            end
        end
    endtask

    // Response becomes visible WAITC+1 edges after the accepting edge and
    // retires on the first edge that sees rsp_ready; reset drops everything.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy  = 1'b0;
            m_shown = 1'b0;
        end else begin
            m_edge++;
            if (m_busy && m_shown) begin
                if (rsp_ready) begin
                    m_busy  = 1'b0;
                    m_shown = 1'b0;
                end
            end else if (m_busy) begin
                if (m_edge == m_access_edge) begin
                    m_access();
                    m_shown = 1'b1;
                end
            end else if (req_valid) begin
                m_we          = req_we;
                m_addr        = req_addr;
                m_wdata       = req_wdata;
                m_wstrb       = req_wstrb;
                m_busy        = 1'b1;
                m_access_edge = m_edge + WAITC + 1;
            end
        end
    end

    always @(negedge clk) begin
        chk1("req_ready", req_ready, reset && !m_busy);
        chk1("rsp_valid", rsp_valid, m_shown);
        chk1("rsp_err", rsp_err, m_shown ? m_err : 1'b0);
        if (!m_shown || m_rknown)
            chk32("rsp_rdata", rsp_rdata, m_shown ? m_rdata : 32'd0);
    end

    // ---------------- stimulus ----------------
    task automatic send_req(input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
        int n = 0;
        @(negedge clk);
        #2;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        while (!req_ready && n < BUDGET) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk1("req_accepted", req_ready, 1'b1);
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        req_we    = ~we;
        req_addr  = 32'h0000_0FFC;
        req_wdata = ~wdata;
        req_wstrb = ~wstrb;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!rsp_valid && lat < BUDGET) begin
            @(posedge clk);
            #2;
            lat++;
        end
        chk1("rsp_arrived", rsp_valid, 1'b1);
    endtask

    task automatic get_rsp(input int hold, output logic [31:0] rdata,
                           output logic err, output int lat);
        wait_valid(lat);
        rdata = rsp_rdata;
        err   = rsp_err;
        repeat (hold) @(posedge clk);
        if (hold > 0) #2;
        rsp_ready = 1'b1;
        @(posedge clk);
        #2;
        rsp_ready = 1'b0;
    endtask

    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, output logic [31:0] rdata,
                        output logic err, output int lat);
        send_req(we, addr, wdata, wstrb);
        get_rsp(0, rdata, err, lat);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk1("ready_after_reset", req_ready, 1'b1);

        xact(1'b1, 32'h0000_0000, 32'h0BAD_C0DE, 4'hF, rd, er, lat);
        xact(1'b1, 32'h0000_0020, 32'h5555_AAAA, 4'hF, rd, er, lat);
        xact(1'b1, 32'h0000_0014, 32'h0A0B_0C0D, 4'hF, rd, er, lat);

        xact(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        chk32("store_rdata_zero", rd, 32'd0);
        chk1("store_err", er, 1'b0);
        chk_int("store_latency", lat, 3);

        xact(1'b0, 32'h0000_0010, 32'd0, 4'h0, rd, er, lat);
        chk32("load_roundtrip", rd, 32'hDEAD_BEEF);
        chk1("load_err", er, 1'b0);
        chk_int("load_latency", lat, 3);

        xact(1'b1, 32'h0000_0010, 32'h1122_3344, 4'b0101, rd, er, lat);
        xact(1'b0, 32'h0000_0010, 32'd0, 4'h0, rd, er, lat);
        chk32("byte_strobes", rd, 32'hDE22_BE44);

        xact(1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, rd, er, lat);
        chk1("nostrobe_store_err", er, 1'b0);
        xact(1'b0, 32'h0000_0010, 32'd0, 4'h0, rd, er, lat);
        chk32("nostrobe_unchanged", rd, 32'hDE22_BE44);

        xact(1'b0, 32'h0000_0012, 32'd0, 4'h0, rd, er, lat);
        chk1("misaligned_err", er, 1'b1);
        chk32("misaligned_rdata", rd, 32'd0);
        xact(1'b0, 32'h0000_1000, 32'd0, 4'h0, rd, er, lat);
        chk1("past_end_err", er, 1'b1);
        xact(1'b0, 32'hFFFF_FFFC, 32'd0, 4'h0, rd, er, lat);
        chk1("top_of_space_err", er, 1'b1);
        xact(1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, rd, er, lat);
        chk1("oob_store_err", er, 1'b1);
        xact(1'b0, 32'h0000_0000, 32'd0, 4'h0, rd, er, lat);
        chk32("no_alias_word0", rd, 32'h0BAD_C0DE);

        xact(1'b1, 32'h0000_0FFC, 32'h7654_3210, 4'hF, rd, er, lat);
        xact(1'b0, 32'h0000_0FFC, 32'd0, 4'h0, rd, er, lat);
        chk32("last_word", rd, 32'h7654_3210);
        chk1("last_word_err", er, 1'b0);

        // backpressure with a second request waiting
        send_req(1'b0, 32'h0000_0010, 32'd0, 4'h0);
        wait_valid(lat);
        rd = rsp_rdata;
        chk32("bp_rdata", rd, 32'hDE22_BE44);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h0000_0014;
        repeat (5) begin
            @(posedge clk);
            #2;
            chk1("bp_req_ready_low", req_ready, 1'b0);
            chk1("bp_rsp_valid_held", rsp_valid, 1'b1);
            chk32("bp_rdata_stable", rsp_rdata, rd);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #2;
        rsp_ready = 1'b0;
        chk1("bp_rsp_done", rsp_valid, 1'b0);
        chk1("bp_ready_after_handshake", req_ready, 1'b1);
        @(posedge clk);
        #2;
        req_valid = 1'b0;
        req_addr  = 32'h0000_0FFC;
        get_rsp(0, rd, er, lat);
        chk32("bp_second_rdata", rd, 32'h0A0B_0C0D);
        chk_int("bp_second_latency", lat, 3);

        // reset during WAIT aborts a store
        send_req(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 4'hF);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk1("rst_wait_rsp_valid", rsp_valid, 1'b0);
        chk1("rst_wait_req_ready", req_ready, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        xact(1'b0, 32'h0000_0020, 32'd0, 4'h0, rd, er, lat);
        chk32("rst_store_aborted", rd, 32'h5555_AAAA);

        // reset while a response is showing
        send_req(1'b0, 32'h0000_0020, 32'd0, 4'h0);
        wait_valid(lat);
        reset = 1'b0;
        #1;
        chk1("rst_resp_valid_low", rsp_valid, 1'b0);
        chk32("rst_resp_rdata_zero", rsp_rdata, 32'd0);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        xact(1'b0, 32'h0000_0014, 32'd0, 4'h0, rd, er, lat);
        chk32("post_reset_load", rd, 32'h0A0B_0C0D);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
